// File: rtl/mux8_rr_scheduler.sv
// mux8_rr_scheduler: round-robin scheduler sharing one registered 8:1 mux
// among 8 requesters. Issues one-hot grants in bursts of up to MAX_BURST
// samples and returns each sampled mux bit tagged with its source index.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   enable       in   low blocks new grants and ends an active grant
//   req[7:0]     in   level-sensitive per-requester request
//   mux_out      in   registered output of the shared mux
//   sel[2:0]     out  select driven to the mux
//   grant[7:0]   out  one-hot grant, zero when idle
//   busy         out  high while a grant is active
//   sample_valid out  one-cycle strobe qualifying sample_bit/sample_src
//   sample_bit   out  captured mux output
//   sample_src   out  requester index that owns sample_bit
module mux8_rr_scheduler #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] req,
    input  logic       mux_out,
    output logic [2:0] sel,
    output logic [7:0] grant,
    output logic       busy,
    output logic       sample_valid,
    output logic       sample_bit,
    output logic [2:0] sample_src
);

    localparam int unsigned N_REQ = 8;
    localparam int unsigned SEL_W = 3;
    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BURST - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t             state;
    logic [SEL_W-1:0]   last;
    logic [CNT_W-1:0]   beat_cnt;
    logic               beat_v;
    logic [SEL_W-1:0]   beat_src;

    logic [SEL_W-1:0]   winner_c;
    logic               beat_c;
    logic               exit_c;

    // First requester above `last`, wrapping; `last` itself is checked last.
    always_comb begin
        logic [SEL_W-1:0] idx;
        logic             found;
        winner_c = last;
        found    = 1'b0;
        idx      = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            idx = last + SEL_W'(i);
            if (!found && req[idx]) begin
                winner_c = idx;
                found    = 1'b1;
            end
        end
    end

    // A beat counts only while the granted requester still asks and enable is high.
    always_comb begin
        beat_c = req[sel] & enable;
        exit_c = !beat_c || (beat_cnt == LAST_BEAT);
    end

    // Arbitration FSM plus the two-stage sample tag pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            last         <= SEL_W'(N_REQ - 1);
            sel          <= '0;
            grant        <= '0;
            busy         <= 1'b0;
            beat_cnt     <= '0;
            beat_v       <= 1'b0;
            beat_src     <= '0;
            sample_valid <= 1'b0;
            sample_bit   <= 1'b0;
            sample_src   <= '0;
        end else begin
            // Tag stage lines up with the mux register; output stage one edge later.
            beat_v       <= 1'b0;
            beat_src     <= sel;
            sample_valid <= beat_v;
            sample_bit   <= mux_out;
            sample_src   <= beat_src;

            case (state)
                IDLE: begin
                    if (enable && (req != '0)) begin
                        sel      <= winner_c;
                        grant    <= 8'b1 << winner_c;
                        busy     <= 1'b1;
                        beat_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    if (beat_c) begin
                        beat_v   <= 1'b1;
                        beat_cnt <= beat_cnt + CNT_W'(1);
                    end
                    // sel holds on exit so the mux select never glitches mid-pipeline.
                    if (exit_c) begin
                        grant    <= '0;
                        busy     <= 1'b0;
                        last     <= sel;
                        beat_cnt <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux8_rr_scheduler.sv
// Testbench for mux8_rr_scheduler: cycle table for grant/sel/busy/strobe,
// sample scoreboard queues, hand sequences for reset mid-burst, a full
// round-robin sweep and a MAX_BURST=1 instance.
module tb_mux8_rr_scheduler;

    logic       clk;
    logic       rst;

    logic       en_a, mux_out_a, busy_a, sv_a, sb_a;
    logic [7:0] req_a, grant_a, data_a;
    logic [2:0] sel_a, ss_a;

    logic       en_b, mux_out_b, busy_b, sv_b, sb_b;
    logic [7:0] req_b, grant_b, data_b;
    logic [2:0] sel_b, ss_b;

    typedef struct {
        logic [7:0] req;
        logic       en;
        logic [7:0] grant;
        logic [2:0] sel;
        logic       sv;
    } vec_t;

    vec_t       tbl [0:34];
    logic [3:0] q_a [$];
    logic [3:0] q_b [$];
    logic [3:0] mon_exp;
    int         n_cmp = 0;
    int         n_err = 0;

    mux8_rr_scheduler #(.MAX_BURST(4)) dut_a (
        .clk(clk), .rst(rst), .enable(en_a), .req(req_a), .mux_out(mux_out_a),
        .sel(sel_a), .grant(grant_a), .busy(busy_a), .sample_valid(sv_a),
        .sample_bit(sb_a), .sample_src(ss_a)
    );

    mux8_rr_scheduler #(.MAX_BURST(1)) dut_b (
        .clk(clk), .rst(rst), .enable(en_b), .req(req_b), .mux_out(mux_out_b),
        .sel(sel_b), .grant(grant_b), .busy(busy_b), .sample_valid(sv_b),
        .sample_bit(sb_b), .sample_src(ss_b)
    );

    // Shared registered 8:1 mux model for each scheduler.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mux_out_a <= 1'b0;
            mux_out_b <= 1'b0;
        end else begin
            mux_out_a <= data_a[sel_a];
            mux_out_b <= data_b[sel_b];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic [7:0] r, logic e, logic [7:0] g, logic [2:0] s, logic v);
        vec_t t;
        t.req = r; t.en = e; t.grant = g; t.sel = s; t.sv = v;
        return t;
    endfunction

    task automatic push_a(input logic [2:0] idx, input int n);
        for (int k = 0; k < n; k++) q_a.push_back({idx, data_a[idx]});
    endtask

    task automatic push_b(input logic [2:0] idx);
        q_b.push_back({idx, data_b[idx]});
    endtask

    initial begin
        rst = 1'b1;
        en_a = 1'b0; req_a = '0; data_a = '0;
        en_b = 1'b0; req_b = '0; data_b = '0;

        fork
            // Sample monitor: every strobe must match the head of its scoreboard queue.
            forever begin
                @(negedge clk);
                if (sv_a) begin
                    if (q_a.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL sample_a: got src=%0d bit=%0d expected no sample", ss_a, sb_a);
                    end else begin
                        mon_exp = q_a.pop_front();
                        check("sample_a", 32'({ss_a, sb_a}), 32'(mon_exp));
                    end
                end
                if (sv_b) begin
                    if (q_b.size() == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL sample_b: got src=%0d bit=%0d expected no sample", ss_b, sb_b);
                    end else begin
                        mon_exp = q_b.pop_front();
                        check("sample_b", 32'({ss_b, sb_b}), 32'(mon_exp));
                    end
                end
            end
            begin
                #100000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1, "watchdog expired");
            end
        join_none

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        check("rst_sel",   32'(sel_a),   32'(0));
        check("rst_grant", 32'(grant_a), 32'(0));
        check("rst_busy",  32'(busy_a),  32'(0));
        check("rst_sv",    32'(sv_a),    32'(0));
        check("rst_sbit",  32'(sb_a),    32'(0));
        check("rst_ssrc",  32'(ss_a),    32'(0));
        check("rst_grant_b", 32'(grant_b), 32'(0));
        check("rst_busy_b",  32'(busy_b),  32'(0));

        // Cycle table: {req, enable, grant, sel, sample_valid} after each edge.
        tbl[0]  = mk(8'h01, 1'b1, 8'h01, 3'd0, 1'b0);
        tbl[1]  = mk(8'h01, 1'b1, 8'h01, 3'd0, 1'b0);
        tbl[2]  = mk(8'h01, 1'b1, 8'h01, 3'd0, 1'b1);
        tbl[3]  = mk(8'h01, 1'b1, 8'h01, 3'd0, 1'b1);
        tbl[4]  = mk(8'h01, 1'b1, 8'h00, 3'd0, 1'b1);
        tbl[5]  = mk(8'h01, 1'b1, 8'h01, 3'd0, 1'b1);
        tbl[6]  = mk(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
        tbl[7]  = mk(8'h00, 1'b1, 8'h00, 3'd0, 1'b0);
        tbl[8]  = mk(8'h04, 1'b1, 8'h04, 3'd2, 1'b0);
        tbl[9]  = mk(8'h04, 1'b1, 8'h04, 3'd2, 1'b0);
        tbl[10] = mk(8'h04, 1'b1, 8'h04, 3'd2, 1'b1);
        tbl[11] = mk(8'h04, 1'b1, 8'h04, 3'd2, 1'b1);
        tbl[12] = mk(8'h04, 1'b1, 8'h00, 3'd2, 1'b1);
        tbl[13] = mk(8'h24, 1'b1, 8'h20, 3'd5, 1'b1);
        tbl[14] = mk(8'h24, 1'b1, 8'h20, 3'd5, 1'b0);
        tbl[15] = mk(8'h24, 1'b1, 8'h20, 3'd5, 1'b1);
        tbl[16] = mk(8'h24, 1'b1, 8'h20, 3'd5, 1'b1);
        tbl[17] = mk(8'h24, 1'b1, 8'h00, 3'd5, 1'b1);
        tbl[18] = mk(8'h24, 1'b1, 8'h04, 3'd2, 1'b1);
        tbl[19] = mk(8'h00, 1'b1, 8'h00, 3'd2, 1'b0);
        tbl[20] = mk(8'h00, 1'b1, 8'h00, 3'd2, 1'b0);
        tbl[21] = mk(8'h08, 1'b1, 8'h08, 3'd3, 1'b0);
        tbl[22] = mk(8'h08, 1'b1, 8'h08, 3'd3, 1'b0);
        tbl[23] = mk(8'h08, 1'b1, 8'h08, 3'd3, 1'b1);
        tbl[24] = mk(8'h00, 1'b1, 8'h00, 3'd3, 1'b1);
        tbl[25] = mk(8'h00, 1'b1, 8'h00, 3'd3, 1'b0);
        tbl[26] = mk(8'hFF, 1'b1, 8'h10, 3'd4, 1'b0);
        tbl[27] = mk(8'h00, 1'b1, 8'h00, 3'd4, 1'b0);
        tbl[28] = mk(8'h00, 1'b1, 8'h00, 3'd4, 1'b0);
        tbl[29] = mk(8'hFF, 1'b0, 8'h00, 3'd4, 1'b0);
        tbl[30] = mk(8'hFF, 1'b0, 8'h00, 3'd4, 1'b0);
        tbl[31] = mk(8'hFF, 1'b1, 8'h20, 3'd5, 1'b0);
        tbl[32] = mk(8'hFF, 1'b1, 8'h20, 3'd5, 1'b0);
        tbl[33] = mk(8'hFF, 1'b0, 8'h00, 3'd5, 1'b1);
        tbl[34] = mk(8'h00, 1'b1, 8'h00, 3'd5, 1'b0);

        @(negedge clk);
        rst = 1'b0;
        en_a = 1'b1;
        en_b = 1'b1;
        data_a = 8'h29;
        push_a(3'd0, 4);
        push_a(3'd2, 4);
        push_a(3'd5, 4);
        push_a(3'd3, 2);
        push_a(3'd5, 1);

        for (int i = 0; i < 35; i++) begin
            req_a = tbl[i].req;
            en_a  = tbl[i].en;
            step();
            check($sformatf("row%0d_grant", i), 32'(grant_a), 32'(tbl[i].grant));
            check($sformatf("row%0d_busy", i),  32'(busy_a),  32'(tbl[i].grant != 8'h00));
            check($sformatf("row%0d_sel", i),   32'(sel_a),   32'(tbl[i].sel));
            check($sformatf("row%0d_sv", i),    32'(sv_a),    32'(tbl[i].sv));
        end
        en_a = 1'b1;
        repeat (3) step();
        check("table_drain", 32'(q_a.size()), 32'(0));

        // Reset during a burst to index 3: one sample delivered, the rest discarded.
        req_a = 8'h08;
        push_a(3'd3, 1);
        step();
        check("rstburst_grant", 32'(grant_a), 32'(8'h08));
        step();
        step();
        check("rstburst_sv", 32'(sv_a), 32'(1));
        #6;
        rst = 1'b1;
        #1;
        check("rstasync_grant", 32'(grant_a), 32'(0));
        check("rstasync_sel",   32'(sel_a),   32'(0));
        check("rstasync_busy",  32'(busy_a),  32'(0));
        check("rstasync_sv",    32'(sv_a),    32'(0));
        check("rstasync_sbit",  32'(sb_a),    32'(0));
        check("rstasync_ssrc",  32'(ss_a),    32'(0));
        step();
        check("rsthold_sv", 32'(sv_a), 32'(0));
        @(negedge clk);
        rst = 1'b0;
        req_a = 8'h81;
        check("rstburst_drain", 32'(q_a.size()), 32'(0));
        step();
        check("postrst_grant", 32'(grant_a), 32'(8'h01));
        check("postrst_sel",   32'(sel_a),   32'(0));
        rst = 1'b1;
        req_a = 8'h00;
        @(negedge clk);
        rst = 1'b0;

        // Full round robin with req=FF: bursts 0..7,0, four samples each, one idle between.
        data_a = 8'hAA;
        req_a  = 8'hFF;
        for (int b = 0; b < 9; b++) push_a(3'(b % 8), 4);
        for (int b = 0; b < 9; b++) begin
            for (int c = 0; c < 4; c++) begin
                step();
                check($sformatf("rr%0d_grant", b), 32'(grant_a), 32'(8'h01 << (b % 8)));
            end
            step();
            check($sformatf("rr%0d_gap", b), 32'(grant_a), 32'(0));
        end
        req_a = 8'h00;
        repeat (4) step();
        check("rr_drain", 32'(q_a.size()), 32'(0));

        // MAX_BURST=1 with req=81: alternating single-sample grants to 0 and 7.
        data_b = 8'h80;
        req_b  = 8'h81;
        for (int b = 0; b < 6; b++) push_b((b % 2 == 0) ? 3'd0 : 3'd7);
        for (int b = 0; b < 6; b++) begin
            step();
            check($sformatf("mb1_%0d_grant", b), 32'(grant_b), 32'((b % 2 == 0) ? 8'h01 : 8'h80));
            check($sformatf("mb1_%0d_busy", b),  32'(busy_b),  32'(1));
            step();
            check($sformatf("mb1_%0d_gap", b), 32'(grant_b), 32'(0));
        end
        req_b = 8'h00;
        repeat (4) step();
        check("mb1_drain", 32'(q_b.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
